programmable_clock_divider: RTL and testbench

Runtime-programmable integer clock divider. Generalises the fixed power-of-two divider chain to any ratio N in 2..2^DIV_W-1. Ratio changes go through a valid/ready handshake and take effect only at period boundaries, so the output never glitches. Enable and disable are also glitch-free. Used by testbench and peripheral clock generation wherever a software-selectable slow clock is needed.

---
 rtl/programmable_clock_divider_if.sv | 24 ++
 rtl/programmable_clock_divider.sv | 124 ++++++++++++
 tb/tb_programmable_clock_divider.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/programmable_clock_divider_if.sv
// Control/status bundle for the programmable clock divider.
// master = the block that programs the divider, slave = the divider itself.
interface programmable_clock_divider_if #(
  parameter int DIV_W = 8
);
  logic             io_enable;
  logic             io_div_valid;
  logic             io_div_ready;
  logic [DIV_W-1:0] io_div_bits;
  logic             io_clock_out;
  logic             io_tick;
  logic             io_running;
  logic [DIV_W-1:0] io_div_current;

  modport master (
    output io_enable, io_div_valid, io_div_bits,
    input  io_div_ready, io_clock_out, io_tick, io_running, io_div_current
  );

  modport slave (
    input  io_enable, io_div_valid, io_div_bits,
    output io_div_ready, io_clock_out, io_tick, io_running, io_div_current
  );
endinterface

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable integer clock divider, N in 2..2^DIV_W-1.
// High phase ceil(N/2), low phase floor(N/2). Divisor changes and
// enable/disable only take effect at period boundaries, so the output
// (a plain flop) never produces a runt pulse.
module programmable_clock_divider #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  programmable_clock_divider_if.slave   io
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;

  // One extra bit: ceil(N/2) computed as (N+1)>>1 must not wrap at N=2^DIV_W-1.
  logic [DIV_W:0]   high_len;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] div_req;
  logic             at_end;
  logic             ready;
  logic             hs;

  // Period bookkeeping and handshake decode shared by the next-state logic.
  always_comb begin
    high_len = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
    cnt_inc  = cnt_q + ONE;
    at_end   = (state_q == RUN) && (cnt_q == div_q - ONE);
    // In IDLE and at a boundary without a queued value the request can be
    // absorbed directly; otherwise only one request may be outstanding.
    ready    = (state_q == IDLE) || !pend_vld_q;
    hs       = io.io_div_valid && ready;
    div_req  = (io.io_div_bits < MIN_DIV) ? MIN_DIV : io.io_div_bits;
  end

  // Next-state: counter, output phase, divisor staging and run state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (hs) div_d = div_req;
        if (io.io_enable) begin
          state_d = RUN;
          clk_d   = 1'b1;
        end
      end
      RUN: begin
        if (at_end) begin
          // Boundary: a queued divisor wins over a same-cycle request.
          if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
          end else if (hs) begin
            div_d = div_req;
          end
          cnt_d = '0;
          if (io.io_enable) begin
            clk_d = 1'b1;
          end else begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          clk_d = ({1'b0, cnt_inc} < high_len);
          if (hs) begin
            pend_d     = div_req;
            pend_vld_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset forces the output low immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      div_q      <= RST_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign io.io_clock_out   = clk_q;
  assign io.io_tick        = at_end;
  assign io.io_running     = (state_q == RUN);
  assign io.io_div_ready   = ready;
  assign io.io_div_current = div_q;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench for programmable_clock_divider. The reference model
// describes each period as a queue of expected output levels (ceil(N/2)
// ones then floor(N/2) zeros) rather than as a counter.
module tb_programmable_clock_divider;
  localparam int DIV_W     = 8;
  localparam int RESET_DIV = 2;
  localparam int W         = 4 + DIV_W;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  programmable_clock_divider_if #(.DIV_W(DIV_W)) bus ();

  programmable_clock_divider #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  bit   m_run;
  bit   m_pv;
  int   m_div;
  int   m_pend;
  int   m_per;
  bit   q[$];
  logic exp_clk, exp_tick, exp_run, exp_rdy;
  logic [DIV_W-1:0] exp_div;

  function automatic int clampv(input int b);
    return (b < 2) ? 2 : b;
  endfunction

  task automatic build(input int n);
    int h;
    h = (n + 1) / 2;
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(i < h);
    m_per = n;
  endtask

  task automatic set_exp();
    exp_clk  = m_run ? q[0] : 1'b0;
    exp_tick = m_run && (q.size() == 1);
    exp_run  = m_run;
    exp_rdy  = !m_run || !m_pv;
    exp_div  = DIV_W'(m_div);
  endtask

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_div = RESET_DIV; m_pend = 0; m_per = 0;
    q.delete();
    set_exp();
  endtask

  task automatic model_step();
    bit hs;
    int cl;
    if (!reset_n) begin
      model_reset();
      return;
    end
    hs = bus.io_div_valid && exp_rdy;
    cl = clampv(int'(bus.io_div_bits));
    if (!m_run) begin
      if (hs) m_div = cl;
      if (bus.io_enable) begin
        m_run = 1;
        build(m_div);
      end
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (m_pv) begin
          m_div = m_pend; m_pv = 0;
        end else if (hs) begin
          m_div = cl;
        end
        if (bus.io_enable) build(m_div);
        else m_run = 0;
      end else if (hs) begin
        m_pend = cl; m_pv = 1;
      end
    end
    set_exp();
  endtask

  function automatic int m_pos();
    return m_per - q.size();
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {bus.io_clock_out, bus.io_tick, bus.io_running, bus.io_div_ready, bus.io_div_current};
  endfunction

  function automatic logic [W-1:0] exp_vec();
    return {exp_clk, exp_tick, exp_run, exp_rdy, exp_div};
  endfunction

  // Advance one reference cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic wait_pos(input int k);
    int g = 0;
    while (!(m_run && m_pos() == k) && g < 1000) begin cyc(); g++; end
    if (g >= 1000) begin
      errors++;
      $display("FAIL wait_pos timeout actual_pos=%0d required_pos=%0d", m_pos(), k);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    bus.io_enable = 1'b0;
    while (m_run && g < 1000) begin cyc(); g++; end
    if (g >= 1000) begin
      errors++;
      $display("FAIL wait_idle timeout");
    end
  endtask

  task automatic write_div(input int n);
    bus.io_div_valid = 1'b1;
    bus.io_div_bits  = DIV_W'(n);
    cyc();
    bus.io_div_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    repeat (2) begin
      cyc();
      checks++;
      if (act_vec() !== {1'b0, 1'b0, 1'b0, 1'b1, DIV_W'(RESET_DIV)}) begin
        errors++;
        $display("FAIL reset_state actual=%h required=%h", act_vec(),
                 {1'b0, 1'b0, 1'b0, 1'b1, DIV_W'(RESET_DIV)});
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_div2();
    bus.io_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL div2 cyc=%0d actual=%h required=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.io_running !== 1'b1) begin
      errors++;
      $display("FAIL div2_running actual=%b required=1", bus.io_running);
    end
  endtask

  task automatic test_idle_write5();
    int ticks = 0;
    wait_idle();
    write_div(5);
    checks++;
    if (bus.io_div_current !== 8'd5) begin
      errors++;
      $display("FAIL idle5_div actual=%0d required=5", bus.io_div_current);
    end
    bus.io_enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (bus.io_tick === 1'b1) ticks++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle5 cyc=%0d actual=%h required=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (ticks !== 3) begin
      errors++;
      $display("FAIL idle5_ticks actual=%0d required=3", ticks);
    end
  endtask

  task automatic test_pending_change();
    wait_idle();
    write_div(4);
    bus.io_enable = 1'b1;
    wait_pos(1);
    write_div(7);
    checks++;
    if (bus.io_div_ready !== 1'b0 || bus.io_div_current !== 8'd4) begin
      errors++;
      $display("FAIL pend_ready actual=%b/%0d required=0/4", bus.io_div_ready, bus.io_div_current);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pend cyc=%0d actual=%h required=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.io_div_current !== 8'd7 || bus.io_div_ready !== 1'b1) begin
      errors++;
      $display("FAIL pend_applied actual=%0d/%b required=7/1", bus.io_div_current, bus.io_div_ready);
    end
  endtask

  task automatic test_boundary_bypass();
    int g = 0;
    bus.io_enable = 1'b1;
    write_div(6);
    while (!(m_run && m_per == 6 && q.size() == 1 && !m_pv) && g < 1000) begin cyc(); g++; end
    checks++;
    if (bus.io_tick !== 1'b1 || g >= 1000) begin
      errors++;
      $display("FAIL bypass_tick actual=%b required=1", bus.io_tick);
    end
    write_div(3);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bypass cyc=%0d actual=%h required=%h", i, act_vec(), exp_vec());
      end
      cyc();
    end
    checks++;
    if (bus.io_div_current !== 8'd3) begin
      errors++;
      $display("FAIL bypass_div actual=%0d required=3", bus.io_div_current);
    end
  endtask

  task automatic test_clamp();
    int vals[3] = '{0, 1, 255};
    int want[3] = '{2, 2, 255};
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      write_div(vals[i]);
      checks++;
      if (bus.io_div_current !== DIV_W'(want[i])) begin
        errors++;
        $display("FAIL clamp in=%0d actual=%0d required=%0d", vals[i], bus.io_div_current, want[i]);
      end
    end
  endtask

  task automatic test_disable();
    wait_idle();
    write_div(8);
    bus.io_enable = 1'b1;
    wait_pos(2);
    bus.io_enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL disable cyc=%0d actual=%h required=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.io_running !== 1'b0 || bus.io_clock_out !== 1'b0) begin
      errors++;
      $display("FAIL disable_idle actual=%b%b required=00", bus.io_running, bus.io_clock_out);
    end
  endtask

  task automatic test_reset_midperiod();
    wait_idle();
    write_div(9);
    bus.io_enable = 1'b1;
    wait_pos(2);
    write_div(5);
    checks++;
    if (bus.io_clock_out !== 1'b1 || m_pos() != 3 || bus.io_div_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_setup actual=%b/%b required=1/0", bus.io_clock_out, bus.io_div_ready);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.io_clock_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_async actual=%b required=0", bus.io_clock_out);
    end
    model_reset();
    bus.io_enable = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    checks++;
    if (act_vec() !== {1'b0, 1'b0, 1'b0, 1'b1, DIV_W'(RESET_DIV)}) begin
      errors++;
      $display("FAIL rst_release actual=%h required=%h", act_vec(),
               {1'b0, 1'b0, 1'b0, 1'b1, DIV_W'(RESET_DIV)});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.io_enable    = ($urandom_range(0, 9) != 0);
      bus.io_div_valid = ($urandom_range(0, 3) == 0);
      bus.io_div_bits  = DIV_W'($urandom_range(0, 9));
      cyc();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d actual=%h required=%h", i, act_vec(), exp_vec());
      end
    end
    bus.io_div_valid = 1'b0;
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.io_enable    = 1'b0;
    bus.io_div_valid = 1'b0;
    bus.io_div_bits  = '0;
    #1;
    test_reset();
    test_div2();
    test_idle_write5();
    test_pending_change();
    test_boundary_bypass();
    test_clamp();
    test_disable();
    test_reset_midperiod();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
